piped_adder_sched: RTL and testbench
====================================

// Module: piped_adder_sched
// PURPOSE
//  Time-shares one piped_adder tree between N_REQ requesters (e.g. CRPA beam/channel sum jobs).
//  - Round-robin arbiter accepts at most one argument vector per clk.
//  - Zero-pads the vector to a power of two and feeds it to the adder.
//  - A tag delay line returns each sum with the ID of its requester.
//  Sits between the CRPA weighting stages and the downstream beam outputs.
// PARAMETERS
//  N_REQ    4   number of requesters, >=2
//  N_ARGS   8   arguments per vector, >=2; need not be a power of two
//  ARG_W    14  signed width of each argument
//  ADD_LAT  3   piped_adder latency in clk; must equal `CLOG2(N_ARGS)
//  CNT_W    32  width of issue_cnt
// PORTS
//  clk        in   1                   clock
//  resetn     in   1                   asynchronous, active-low reset
//  clr        in   1                   synchronous flush of in-flight work
//  req_valid  in   N_REQ               per-requester vector valid
//  req_ready  out  N_REQ               one-hot grant; transfer when valid&ready
//  req_args   in   N_REQ*N_ARGS*ARG_W  requester r occupies slice r; arg k at [k*ARG_W +: ARG_W] within it
//  res_valid  out  1                   result strobe, 1 clk, no backpressure
//  res_id     out  CLOG2(N_REQ)        requester index of res_sum
//  res_sum    out  SUM_W               signed sum; SUM_W = ARG_W + `CLOG2(N_ARGS)
//  busy       out  1                   any job in flight
//  issue_cnt  out  CNT_W               accepted vectors since reset, wraps
// BEHAVIOUR
//  Reset: asynchronous, active-low.
//   - res_valid, res_id, res_sum, busy, issue_cnt, rr_ptr and all tag valids go to 0.
//   - req_ready is 0 while resetn is low.
//   - Jobs in flight when reset asserts are lost; no result is produced for them.
//  Arbitration:
//   - req_ready is combinational from req_valid and rr_ptr.
//   - Grant goes to the first r with req_valid[r]=1, searching cyclically from rr_ptr.
//   - On a grant g, rr_ptr <= (g+1) mod N_REQ. With no request, rr_ptr holds.
//   - clr=1 forces req_ready=0 in that cycle.
//   - A requester may not drop req_valid before it sees req_ready.
//  Issue:
//   - On transfer, the granted slice is registered into the adder input register.
//   - Upper `CLOG2-padded slots are filled with zeros.
//   - The adder is driven with we=1 every cycle.
//   - {valid, id} enters tag stage 0 in the same cycle.
//  Latency and throughput:
//   - Transfer at clk edge T gives res_valid=1 at edge T+1+ADD_LAT.
//   - res_sum and res_id come out of the final tag/output register.
//   - Throughput is 1 vector/clk.
//   - Results leave in grant order.
//  Arithmetic:
//   - Sign-extended, exact; no overflow possible at SUM_W.
//   - res_sum holds its last value when res_valid=0.
//  clr:
//   - Clears all tag valids on the next edge, so in-flight sums never assert res_valid.
//   - The adder datapath is not reset.
//   - busy falls on that edge if no new grant occurs.
//   - clr and a request in the same cycle: the request is not accepted.
//  Other rules:
//   - busy = OR of tag valids and the input-register valid.
//   - issue_cnt increments on each transfer and wraps to 0 after all ones.
//  Assertion (sim only): piped_adder valid == tag valid at the adder output stage.
// STRUCTURE
//  - CRPA_param.v holds the `CLOG2 macro and the default MSUM-style widths.
//  - Derived widths (SUM_W, ID_W, padded N2) are localparams.
//  - Sub-module pa_rr_arbiter: N_REQ-wide round-robin one-hot grant with rr_ptr state.
//  - Existing piped_adder instance, configured with N_args=2**`CLOG2(N_ARGS) and arg_width=ARG_W.
//  - Tag shift register and padding logic stay in this module.
// TESTING (N_REQ=4, N_ARGS=8, ARG_W=14, ADD_LAT=3)
//  1. Req 0 only, args 1..8, one transfer at edge T
//     -> res_valid at T+4, res_id=0, res_sum=36; busy high T+1..T+4.
//  2. All 4 requesters valid continuously, each with args all = r+1
//     -> grants 0,1,2,3,0,... one per clk; sums 8,16,24,32 in order, back-to-back.
//  3. Req 2 with all args -8192, req 3 with all args 8191
//     -> sums -65536 and 65528, exact in 17 bits.
//  4. Three jobs in flight, pulse clr with req 1 valid
//     -> no res_valid for the flushed jobs; req_ready[1]=0 that cycle; req 1 granted next cycle, result 4 clk later.
//  5. resetn low mid-stream
//     -> outputs 0 immediately; after release, the lowest valid index is granted first; issue_cnt restarts at 0.
//  6. N_ARGS=5 build, args 1..5 (ADD_LAT=3)
//     -> res_sum=15; padding slots contribute 0.

Source files
------------

// File: rtl/piped_adder_sched_pkg.sv
// rtl/piped_adder_sched_pkg.sv - shared defaults and width helpers for piped_adder_sched
package piped_adder_sched_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_N_ARGS  = 8;
    localparam int DEF_ARG_W   = 14;
    localparam int DEF_ADD_LAT = 3;
    localparam int DEF_CNT_W   = 32;

    // Argument slots seen by the adder tree: N_ARGS rounded up to a power of two.
    function automatic int pad_pow2(input int n);
        return 1 << $clog2(n);
    endfunction

endpackage

// File: rtl/pa_rr_arbiter.sv
// rtl/pa_rr_arbiter.sv - N-wide round-robin one-hot grant with rotating priority pointer
module pa_rr_arbiter #(
    parameter  int N    = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            en,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id
);

    logic [ID_W-1:0] rr_ptr;
    logic            found;
    int              idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found  = 1'b1;
                gnt_id = ID_W'(idx);
            end
        end
        if (found && en && resetn) gnt[gnt_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= '0;
        end else if (|gnt) begin
            rr_ptr <= (gnt_id == ID_W'(N-1)) ? '0 : gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/piped_adder.sv
// rtl/piped_adder.sv - registered binary adder tree, one level per clk, with valid sideband
module piped_adder #(
    parameter  int N_args    = 8,
    parameter  int arg_width = 14,
    localparam int LAT       = $clog2(N_args),
    localparam int OUT_W     = arg_width + LAT
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          we,
    input  logic                          clr,
    input  logic                          in_valid,
    input  logic [N_args*arg_width-1:0]   args,
    output logic                          out_valid,
    output logic signed [OUT_W-1:0]       sum
);

    localparam int HALF = N_args / 2;

    logic signed [OUT_W-1:0] ext   [N_args];
    logic signed [OUT_W-1:0] stage [1:LAT][HALF];
    logic                    vld   [1:LAT];

    always_comb begin
        for (int j = 0; j < N_args; j++) begin
            ext[j] = OUT_W'($signed(args[j*arg_width +: arg_width]));
        end
    end

    // Entries beyond the live width of a level are kept at zero so every slot is defined.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int j = 0; j < HALF; j++) begin
                stage[1][j] <= ext[2*j] + ext[2*j+1];
            end
            for (int l = 2; l <= LAT; l++) begin
                for (int j = 0; j < HALF; j++) begin
                    if (j < (N_args >> l)) begin
                        stage[l][j] <= stage[l-1][2*j] + stage[l-1][2*j+1];
                    end else begin
                        stage[l][j] <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int l = 1; l <= LAT; l++) vld[l] <= 1'b0;
        end else begin
            vld[1] <= in_valid & ~clr;
            for (int l = 2; l <= LAT; l++) vld[l] <= vld[l-1] & ~clr;
        end
    end

    assign sum       = stage[LAT][0];
    assign out_valid = vld[LAT];

endmodule

// File: rtl/piped_adder_sched.sv
// rtl/piped_adder_sched.sv - time-shares one piped_adder tree between N_REQ requesters
module piped_adder_sched
    import piped_adder_sched_pkg::*;
#(
    parameter  int N_REQ   = DEF_N_REQ,
    parameter  int N_ARGS  = DEF_N_ARGS,
    parameter  int ARG_W   = DEF_ARG_W,
    parameter  int ADD_LAT = DEF_ADD_LAT,
    parameter  int CNT_W   = DEF_CNT_W,
    localparam int ID_W    = $clog2(N_REQ),
    localparam int SUM_W   = ARG_W + $clog2(N_ARGS)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          clr,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*N_ARGS*ARG_W-1:0] req_args,
    output logic                          res_valid,
    output logic [ID_W-1:0]               res_id,
    output logic signed [SUM_W-1:0]       res_sum,
    output logic                          busy,
    output logic [CNT_W-1:0]              issue_cnt
);

    localparam int N2    = pad_pow2(N_ARGS);
    localparam int VEC_W = N_ARGS * ARG_W;

    logic [N_REQ-1:0]        gnt;
    logic [ID_W-1:0]         gnt_id;
    logic                    xfer;
    logic [N2*ARG_W-1:0]     in_args;
    logic                    tag_valid [0:ADD_LAT];
    logic [ID_W-1:0]         tag_id    [0:ADD_LAT];
    logic                    add_valid;
    logic signed [SUM_W-1:0] add_sum;

    pa_rr_arbiter #(.N(N_REQ)) u_arb (
        .clk    (clk),
        .resetn (resetn),
        .en     (~clr),
        .req    (req_valid),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;

    // Zero-extension of the slice fills the padded upper slots with zeros.
    always_ff @(posedge clk) begin
        if (xfer) in_args <= (N2*ARG_W)'(req_args[gnt_id*VEC_W +: VEC_W]);
    end

    piped_adder #(.N_args(N2), .arg_width(ARG_W)) u_add (
        .clk       (clk),
        .resetn    (resetn),
        .we        (1'b1),
        .clr       (clr),
        .in_valid  (tag_valid[0]),
        .args      (in_args),
        .out_valid (add_valid),
        .sum       (add_sum)
    );

    // Stage 0 tracks the adder input register; stage ADD_LAT lines up with the adder output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k <= ADD_LAT; k++) begin
                tag_valid[k] <= 1'b0;
                tag_id[k]    <= '0;
            end
        end else begin
            tag_valid[0] <= xfer;
            tag_id[0]    <= gnt_id;
            for (int k = 1; k <= ADD_LAT; k++) begin
                tag_valid[k] <= tag_valid[k-1] & ~clr;
                tag_id[k]    <= tag_id[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_sum   <= '0;
            issue_cnt <= '0;
        end else begin
            res_valid <= tag_valid[ADD_LAT] & ~clr;
            if (tag_valid[ADD_LAT] && !clr) begin
                res_id  <= tag_id[ADD_LAT];
                res_sum <= add_sum;
            end
            if (xfer) issue_cnt <= issue_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k <= ADD_LAT; k++) busy = busy | tag_valid[k];
    end

    a_tag_align: assert property (@(posedge clk) disable iff (!resetn)
        add_valid == tag_valid[ADD_LAT]);

endmodule

// File: tb/tb_piped_adder_sched.sv
// tb/tb_piped_adder_sched.sv - randomized self-checking bench for piped_adder_sched
module tb_piped_adder_sched;

    localparam int N_REQ = 4;
    localparam int N_ARGS = 8;
    localparam int ARG_W = 14;
    localparam int SUM_W = 17;
    localparam int N5 = 5;

    logic                          clk = 1'b0;
    logic                          resetn;
    logic                          clr;
    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ-1:0]              req_ready;
    logic [N_REQ*N_ARGS*ARG_W-1:0] req_args;
    logic                          res_valid;
    logic [1:0]                    res_id;
    logic [SUM_W-1:0]              res_sum;
    logic                          busy;
    logic [31:0]                   issue_cnt;

    logic                          clr_5;
    logic [N_REQ-1:0]              req_valid_5;
    logic [N_REQ-1:0]              req_ready_5;
    logic [N_REQ*N5*ARG_W-1:0]     req_args_5;
    logic                          res_valid_5;
    logic [1:0]                    res_id_5;
    logic [SUM_W-1:0]              res_sum_5;
    logic                          busy_5;
    logic [31:0]                   issue_cnt_5;

    piped_adder_sched #(.N_REQ(N_REQ), .N_ARGS(N_ARGS), .ARG_W(ARG_W), .ADD_LAT(3), .CNT_W(32)) u_dut (
        .clk(clk), .resetn(resetn), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
        .req_args(req_args), .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum),
        .busy(busy), .issue_cnt(issue_cnt)
    );

    piped_adder_sched #(.N_REQ(N_REQ), .N_ARGS(N5), .ARG_W(ARG_W), .ADD_LAT(3), .CNT_W(32)) u_dut5 (
        .clk(clk), .resetn(resetn), .clr(clr_5), .req_valid(req_valid_5), .req_ready(req_ready_5),
        .req_args(req_args_5), .res_valid(res_valid_5), .res_id(res_id_5), .res_sum(res_sum_5),
        .busy(busy_5), .issue_cnt(issue_cnt_5)
    );

    always #5 clk = ~clk;

    typedef struct {int due; int id; int sum;} exp_t;

    exp_t       exp_q[$];
    int         args_m [N_REQ][N_ARGS];
    logic [3:0] vld_m;
    int         rr_m;
    longint     issue_m;
    int         last_sum_m;
    int         edge_cnt = 0;
    int         n_vec = 0;
    int         n_bad = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
            chk("res_valid", longint'(res_valid), 1);
            chk("res_id", longint'(res_id), exp_q[0].id);
            chk("res_sum", longint'($signed(res_sum)), exp_q[0].sum);
            last_sum_m = exp_q[0].sum;
            void'(exp_q.pop_front());
        end else begin
            chk("res_valid_idle", longint'(res_valid), 0);
            chk("res_sum_hold", longint'($signed(res_sum)), last_sum_m);
        end
        chk("busy", longint'(busy), (exp_q.size() > 0) ? 1 : 0);
        chk("issue_cnt", longint'(issue_cnt), issue_m);
    endtask

    task automatic new_args(input int r, input int mode);
        for (int k = 0; k < N_ARGS; k++) begin
            case (mode)
                1:       args_m[r][k] = r + 1;
                2:       args_m[r][k] = (r == 2) ? -8192 : (r == 3) ? 8191 : int'($urandom_range(0, 16383)) - 8192;
                3:       args_m[r][k] = k + 1;
                default: args_m[r][k] = int'($urandom_range(0, 16383)) - 8192;
            endcase
        end
    endtask

    // One clock: check last edge's outputs, present new requests, check the grant, update the model.
    task automatic cycle(input logic [3:0] want, input bit do_clr, input int mode);
        int         g;
        int         idx;
        int         s;
        logic [3:0] exp_rdy;
        @(negedge clk);
        check_outputs();
        for (int r = 0; r < N_REQ; r++) begin
            if (!vld_m[r] && want[r]) begin
                vld_m[r] = 1'b1;
                new_args(r, mode);
            end
        end
        req_valid = vld_m;
        clr = do_clr;
        for (int r = 0; r < N_REQ; r++)
            for (int k = 0; k < N_ARGS; k++)
                req_args[(r*N_ARGS+k)*ARG_W +: ARG_W] = ARG_W'(args_m[r][k]);
        if (do_clr) exp_q.delete();
        #1;
        g = -1;
        if (!do_clr) begin
            for (int i = 0; i < N_REQ; i++) begin
                idx = (rr_m + i) % N_REQ;
                if (g < 0 && vld_m[idx]) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
        chk("req_ready", longint'(req_ready), longint'(exp_rdy));
        if (g >= 0) begin
            s = 0;
            for (int k = 0; k < N_ARGS; k++) s += args_m[g][k];
            exp_q.push_back('{edge_cnt + 5, g, s});
            issue_m++;
            vld_m[g] = 1'b0;
            rr_m = (g + 1) % N_REQ;
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_res_valid"}, longint'(res_valid), 0);
        chk({tag, "_res_sum"}, longint'($signed(res_sum)), 0);
        chk({tag, "_res_id"}, longint'(res_id), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_issue_cnt"}, longint'(issue_cnt), 0);
        chk({tag, "_req_ready"}, longint'(req_ready), 0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        vld_m = '0;
        req_valid = '0;
        clr = 1'b0;
        rr_m = 0;
        issue_m = 0;
        last_sum_m = 0;
    endtask

    task automatic run_dut5(input int sgn);
        int n;
        @(negedge clk);
        for (int k = 0; k < N5; k++) req_args_5[k*ARG_W +: ARG_W] = ARG_W'((k + 1) * sgn);
        req_valid_5 = 4'b0001;
        #1;
        chk("d5_ready", longint'(req_ready_5), 1);
        @(negedge clk);
        req_valid_5 = '0;
        n = 11;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (res_valid_5) begin
                n = i;
                break;
            end
        end
        chk("d5_latency", n, 4);
        chk("d5_sum", longint'($signed(res_sum_5)), 15 * sgn);
        chk("d5_id", longint'(res_id_5), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        req_args = '0;
        req_args_5 = '0;
        req_valid_5 = '0;
        clr_5 = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        reset_checks("rst0");
        resetn = 1'b1;

        // single job from requester 0, args 1..8
        cycle(4'b0001, 1'b0, 3);
        repeat (6) cycle(4'b0000, 1'b0, 0);

        // all requesters, args r+1, back to back
        repeat (16) cycle(4'b1111, 1'b0, 1);
        repeat (8) cycle(4'b0000, 1'b0, 0);

        // extremes
        repeat (6) cycle(4'b1100, 1'b0, 2);
        repeat (8) cycle(4'b0000, 1'b0, 0);

        // flush three in-flight jobs while requester 1 waits
        repeat (3) cycle(4'b0001, 1'b0, 0);
        cycle(4'b0010, 1'b1, 0);
        repeat (8) cycle(4'b0000, 1'b0, 0);

        // randomized traffic with occasional flushes
        for (int i = 0; i < 300; i++)
            cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0), 0);

        // reset mid-stream
        repeat (4) cycle(4'b1111, 1'b0, 0);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        reset_checks("rst1");
        clear_model();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        cycle(4'b1100, 1'b0, 0);
        repeat (12) cycle(4'b0000, 1'b0, 0);
        chk("drain", exp_q.size(), 0);

        run_dut5(1);
        run_dut5(-1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
